if_prefetch_stage: RTL and testbench
====================================

IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, 2..16.
REQ-002 Parameter MAX_OUTSTANDING, default 2, maximum issued-but-unanswered memory requests; 1..4.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  system clock; all state changes on rising edge only.
REQ-005 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-006 ex_take_branch_out  in  1  redirect request from EX.
REQ-007 ex_target_PC_out  in  32  redirect target; used only when ex_take_branch_out=1.
REQ-008 proc2Imem_req  out  1  fetch request valid.
REQ-009 proc2Imem_addr  out  32  fetch address, bits [1:0] always 2'b00.
REQ-010 Imem2proc_gnt  in  1  request accepted when proc2Imem_req & Imem2proc_gnt in same cycle.
REQ-011 Imem2proc_valid  in  1  response valid; responses return in request order, one per cycle max, at least one cycle after grant.
REQ-012 Imem2proc_data  in  32  response instruction word.
REQ-013 id_ready  in  1  decode accepts head instruction this cycle.
REQ-014 if_valid_inst_out  out  1  head entry valid.
REQ-015 if_PC_out / if_NPC_out / if_IR_out  out  32 each  head PC, head PC+4, head instruction.

Function
REQ-016 Fetch PC register; advances by 4 on each granted request; wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-017 proc2Imem_req = 1 iff (queue count + outstanding count) < FQ_DEPTH, outstanding count < MAX_OUTSTANDING, ex_take_branch_out = 0, not in reset.
REQ-018 proc2Imem_addr = {fetch_PC[31:2], 2'b00}; held stable while req=1 and gnt=0.
REQ-019 Per granted request, its PC is pushed into an in-order tag FIFO of depth MAX_OUTSTANDING; popped on each response.
REQ-020 Non-dropped response pushes {PC, data} into the fetch queue at cycle end; visible at outputs next cycle (1-cycle memory: req cycle N, response N+1, if_valid_inst_out N+2).
REQ-021 if_valid_inst_out = queue non-empty & ~ex_take_branch_out.
REQ-022 Pop when if_valid_inst_out & id_ready; push and pop in same cycle allowed, count unchanged.
REQ-023 Queue can never overflow; a response arriving while full is a design error flagged by a simulation-only assertion.
REQ-024 Redirect (ex_take_branch_out=1): fetch_PC <= {ex_target_PC_out[31:2],2'b00}; queue emptied; drop counter <= outstanding count excluding any response arriving this cycle; that response is discarded.
REQ-025 While drop counter > 0 each response decrements it and is discarded; new requests may issue after redirect cycle; their responses are kept.
REQ-026 Redirect outranks push, pop and grant in the same cycle; a grant coinciding with redirect is impossible per REQ-017.
REQ-027 Back-to-back redirects: latest target wins; drop counter recomputed each redirect cycle.
REQ-028 Pointers wrap modulo FQ_DEPTH; count width clog2(FQ_DEPTH)+1.

Reset
REQ-029 rst=0 at rising edge: fetch_PC=RESET_PC, queue, tag FIFO, outstanding and drop counters cleared, perf counters zero.
REQ-030 During reset and its cycle: proc2Imem_req=0, if_valid_inst_out=0; other outputs 0 except proc2Imem_addr=RESET_PC.
REQ-031 Responses arriving in the first cycle after reset deassertion are discarded (memory must not hold pre-reset requests).

Configuration
REQ-032 Macro IF_PERF_CNT_EN defined: add outputs if_fetch_cnt (32, increments per pop) and if_stall_cnt (32, increments each cycle queue non-empty & id_ready=0); both saturate at 32'hFFFF_FFFF, clear on reset.
REQ-033 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-034 Reset, gnt=1, 1-cycle memory, id_ready=1 -> addrs 0,4,8,... one per cycle; first if_valid_inst_out with PC=0 two cycles after reset release.
REQ-035 id_ready=0 forever, FQ_DEPTH=4 -> exactly 4 requests granted, req drops to 0, queue holds PCs 0,4,8,C in order.
REQ-036 Two outstanding, redirect to 32'h100 -> both stale responses discarded, next visible PC=32'h100, NPC=32'h104.
REQ-037 Redirect in same cycle as pop and a response -> no pop counted, response dropped, queue empty next cycle.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 IF_PERF_CNT_EN defined, id_ready=0 for 5 cycles with queue non-empty then 3 pops -> if_stall_cnt=5, if_fetch_cnt=3.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Instruction-fetch prefetch stage. Issues in-order fetch requests to the
// instruction memory, remembers the PC of every request that is still in
// flight, and collects the returned instruction words into a small fetch
// queue that feeds decode. A branch redirect from EX flushes the queue,
// restarts fetching at the target and discards the responses of every
// request that was already in flight at the time of the redirect.
//
// Optional feature: define IF_PERF_CNT_EN to add two saturating performance
// counters (if_fetch_cnt, if_stall_cnt). Without the macro those ports and
// their counters do not exist.
//
// Parameters
//   FQ_DEPTH         fetch-queue entries (power of two, 2..16)
//   MAX_OUTSTANDING  issued-but-unanswered memory requests (1..4)
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk                  system clock, rising edge
//   rst                  synchronous reset, active low
//   ex_take_branch_out   redirect request from EX
//   ex_target_PC_out     redirect target
//   proc2Imem_req        fetch request valid
//   proc2Imem_addr       fetch address (word aligned)
//   Imem2proc_gnt        memory accepted the request this cycle
//   Imem2proc_valid      response valid (in request order)
//   Imem2proc_data       response instruction word
//   id_ready             decode accepts the head instruction
//   if_valid_inst_out    head entry valid
//   if_PC_out            head PC
//   if_NPC_out           head PC + 4
//   if_IR_out            head instruction
//   if_fetch_cnt         (IF_PERF_CNT_EN) instructions handed to decode
//   if_stall_cnt         (IF_PERF_CNT_EN) cycles decode stalled a full head
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_take_branch_out,
    input  logic [31:0] ex_target_PC_out,
    output logic        proc2Imem_req,
    output logic [31:0] proc2Imem_addr,
    input  logic        Imem2proc_gnt,
    input  logic        Imem2proc_valid,
    input  logic [31:0] Imem2proc_data,
    input  logic        id_ready,
    output logic        if_valid_inst_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_IR_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_fetch_cnt,
    output logic [31:0] if_stall_cnt
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;

    logic [31:0]   fq_pc [FQ_DEPTH];
    logic [31:0]   fq_ir [FQ_DEPTH];
    logic [PW-1:0] fq_head;
    logic [PW-1:0] fq_tail;
    logic [CW-1:0] fq_count;

    logic [31:0]   tag_pc [MAX_OUTSTANDING];
    logic [TW-1:0] tag_head;
    logic [TW-1:0] tag_tail;

    logic [OW-1:0] outst;
    logic [OW-1:0] drop_cnt;
    logic          first_cycle;

    logic          grant;
    logic          resp_fire;
    logic          resp_keep;
    logic          fq_pop;
    logic          fq_nonempty;
    logic [7:0]    occupancy;

    // Request/response handshakes and head presentation. Occupancy counts
    // queued entries plus every in-flight request, so a response always has
    // a free slot waiting for it. A response is ignored in the first cycle
    // after reset and whenever nothing is in flight, because it cannot belong
    // to any request this stage made. Outputs are forced to zero in reset.
    always_comb begin
        occupancy         = 8'(fq_count) + 8'(outst);
        fq_nonempty       = (fq_count != '0);
        proc2Imem_req     = rst && !ex_take_branch_out &&
                            (occupancy < 8'(FQ_DEPTH)) &&
                            (outst < OW'(MAX_OUTSTANDING));
        proc2Imem_addr    = rst ? {fetch_pc[31:2], 2'b00} : {RESET_PC[31:2], 2'b00};
        grant             = proc2Imem_req && Imem2proc_gnt;
        resp_fire         = rst && Imem2proc_valid && !first_cycle && (outst != '0);
        resp_keep         = resp_fire && !ex_take_branch_out && (drop_cnt == '0);
        if_valid_inst_out = rst && fq_nonempty && !ex_take_branch_out;
        fq_pop            = if_valid_inst_out && id_ready;
        if_PC_out         = '0;
        if_NPC_out        = '0;
        if_IR_out         = '0;
        if (if_valid_inst_out) begin
            if_PC_out  = fq_pc[fq_head];
            if_NPC_out = fq_pc[fq_head] + 32'd4;
            if_IR_out  = fq_ir[fq_head];
        end
    end

    // Control state: fetch PC, queue pointers, tag FIFO pointers, the
    // in-flight count and the drop counter. A redirect wins over everything
    // else in its cycle: the queue is emptied and every request still in
    // flight (minus a response landing right now, which is thrown away) is
    // marked for discarding. No grant can coincide with a redirect because
    // the request is suppressed in that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            fq_head     <= '0;
            fq_tail     <= '0;
            fq_count    <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
            outst       <= '0;
            drop_cnt    <= '0;
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;

            if (grant) begin
                tag_tail <= (tag_tail == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_tail + TW'(1);
            end
            if (resp_fire) begin
                tag_head <= (tag_head == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_head + TW'(1);
            end

            case ({grant, resp_fire})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase

            if (ex_take_branch_out) begin
                fetch_pc <= {ex_target_PC_out[31:2], 2'b00};
                fq_head  <= '0;
                fq_tail  <= '0;
                fq_count <= '0;
                drop_cnt <= outst - OW'(resp_fire);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
                if (resp_keep) begin
                    fq_tail <= fq_tail + PW'(1);
                end
                if (fq_pop) begin
                    fq_head <= fq_head + PW'(1);
                end
                case ({resp_keep, fq_pop})
                    2'b10:   fq_count <= fq_count + CW'(1);
                    2'b01:   fq_count <= fq_count - CW'(1);
                    default: fq_count <= fq_count;
                endcase
            end
        end
    end

    // Storage for the tag FIFO and the fetch queue. The contents need no
    // reset: the pointers and counts decide what is valid.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_pc[tag_tail] <= {fetch_pc[31:2], 2'b00};
        end
        if (resp_keep) begin
            fq_pc[fq_tail] <= tag_pc[tag_head];
            fq_ir[fq_tail] <= Imem2proc_data;
        end
    end

`ifndef SYNTHESIS
    // A response that would land in a full queue means the memory returned
    // something this stage never asked for.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(resp_fire && (fq_count == CW'(FQ_DEPTH))));
        end
    end
`endif

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counters: one counts instructions handed to decode, the
    // other counts cycles where decode held back a waiting instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fq_pop && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (fq_nonempty && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign if_fetch_cnt = rst ? fetch_cnt_q : '0;
    assign if_stall_cnt = rst ? stall_cnt_q : '0;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_stage
//
// Bench for if_prefetch_stage. A memory model answers granted requests in
// order after at least one cycle. The reference model treats the stage as
// "a stream of PCs tagged with a redirect epoch": a response is kept only
// if its request was issued in the current epoch and no redirect happens in
// the cycle it returns. Kept words form an ordered list that decode must
// see in exactly that order. A second instance with RESET_PC=FFFF_FFF8
// shares all inputs and is checked for address wrap-around.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;

    localparam int          FQ   = 4;
    localparam int          MO   = 2;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_take;
    logic [31:0] ex_tgt;
    logic        gnt;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        id_ready;

    logic        req,   req2;
    logic [31:0] addr,  addr2;
    logic        valid, valid2;
    logic [31:0] pc_o,  pc_o2;
    logic [31:0] npc_o, npc_o2;
    logic [31:0] ir_o,  ir_o2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

    always #5 clk = ~clk;

    if_prefetch_stage #(.FQ_DEPTH(FQ), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .ex_take_branch_out(ex_take), .ex_target_PC_out(ex_tgt),
        .proc2Imem_req(req), .proc2Imem_addr(addr),
        .Imem2proc_gnt(gnt), .Imem2proc_valid(mem_valid), .Imem2proc_data(mem_data),
        .id_ready(id_ready),
        .if_valid_inst_out(valid), .if_PC_out(pc_o), .if_NPC_out(npc_o), .if_IR_out(ir_o)
`ifdef IF_PERF_CNT_EN
        , .if_fetch_cnt(fetch_cnt), .if_stall_cnt(stall_cnt)
`endif
    );

    if_prefetch_stage #(.FQ_DEPTH(FQ), .MAX_OUTSTANDING(MO), .RESET_PC(RPC2)) dut2 (
        .clk(clk), .rst(rst),
        .ex_take_branch_out(ex_take), .ex_target_PC_out(ex_tgt),
        .proc2Imem_req(req2), .proc2Imem_addr(addr2),
        .Imem2proc_gnt(gnt), .Imem2proc_valid(mem_valid), .Imem2proc_data(mem_data),
        .id_ready(id_ready),
        .if_valid_inst_out(valid2), .if_PC_out(pc_o2), .if_NPC_out(npc_o2), .if_IR_out(ir_o2)
`ifdef IF_PERF_CNT_EN
        , .if_fetch_cnt(fetch_cnt2), .if_stall_cnt(stall_cnt2)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } pend_t;

    entry_t      mq[$];
    pend_t       pend[$];
    logic [31:0] mpc;
    logic [31:0] mpc2;
    int          epoch;
    int          cyc;
    int          checks;
    int          failures;
    int          dut_grants;
    logic        first_after_reset;
    logic [31:0] fetch_m;
    logic [31:0] stall_m;

    // Instruction word the memory holds at a given address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model by what this cycle does.
    task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] tgt,
                                 input logic g, input logic idr, input logic mem_en);
        logic   resp;
        logic   exp_req;
        logic   exp_valid;
        pend_t  fr;
        entry_t e;
        @(negedge clk);
        rst      = r;
        ex_take  = redir;
        ex_tgt   = tgt;
        gnt      = g;
        id_ready = idr;
        resp     = r && mem_en && (pend.size() > 0) && (pend.size() > 0 ? pend[0].cyc < cyc : 1'b0);
        mem_valid = resp || (r && first_after_reset);
        mem_data  = resp ? memWord(pend[0].addr) : $urandom();
        #1;
        if (!r) begin
            checkOutput("rst_req", {31'd0, req}, 32'd0);
            checkOutput("rst_valid", {31'd0, valid}, 32'd0);
            checkOutput("rst_addr", addr, RPC);
            checkOutput("rst_addr2", addr2, RPC2);
            checkOutput("rst_pc", pc_o, 32'd0);
            checkOutput("rst_ir", ir_o, 32'd0);
`ifdef IF_PERF_CNT_EN
            checkOutput("rst_fetch_cnt", fetch_cnt, 32'd0);
            checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
`endif
            mq.delete();
            pend.delete();
            mpc               = RPC;
            mpc2              = RPC2;
            fetch_m           = 32'd0;
            stall_m           = 32'd0;
            first_after_reset = 1'b1;
        end else begin
            exp_req   = ((mq.size() + pend.size()) < FQ) && (pend.size() < MO) && !redir;
            exp_valid = (mq.size() > 0) && !redir;
            checkOutput("req", {31'd0, req}, {31'd0, exp_req});
            checkOutput("req2", {31'd0, req2}, {31'd0, exp_req});
            checkOutput("valid", {31'd0, valid}, {31'd0, exp_valid});
            if (exp_req) begin
                checkOutput("addr", addr, mpc);
                checkOutput("addr2", addr2, mpc2);
            end
            if (exp_valid) begin
                checkOutput("pc", pc_o, mq[0].pc);
                checkOutput("npc", npc_o, mq[0].pc + 32'd4);
                checkOutput("ir", ir_o, mq[0].ir);
            end
`ifdef IF_PERF_CNT_EN
            checkOutput("fetch_cnt", fetch_cnt, fetch_m);
            checkOutput("stall_cnt", stall_cnt, stall_m);
`endif
            if (req && g) dut_grants++;
            if ((mq.size() > 0) && !idr) stall_m++;
            if (exp_valid && idr) begin
                void'(mq.pop_front());
                fetch_m++;
            end
            if (resp) begin
                fr = pend.pop_front();
                if ((fr.epoch == epoch) && !redir) begin
                    e.pc = fr.addr;
                    e.ir = memWord(fr.addr);
                    mq.push_back(e);
                end
            end
            if (redir) begin
                mq.delete();
                epoch++;
                mpc  = {tgt[31:2], 2'b00};
                mpc2 = {tgt[31:2], 2'b00};
            end else if (exp_req && g) begin
                fr.addr  = mpc;
                fr.epoch = epoch;
                fr.cyc   = cyc;
                pend.push_back(fr);
                mpc  = mpc + 32'd4;
                mpc2 = mpc2 + 32'd4;
            end
            first_after_reset = 1'b0;
        end
        cyc++;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    endtask

    // Directed scenarios first, then a long randomized run.
    initial begin
        rst = 1'b0; ex_take = 1'b0; ex_tgt = '0; gnt = 1'b0;
        mem_valid = 1'b0; mem_data = '0; id_ready = 1'b0;
        checks = 0; failures = 0; epoch = 0; cyc = 0; dut_grants = 0;
        first_after_reset = 1'b0; mpc = RPC; mpc2 = RPC2;
        fetch_m = '0; stall_m = '0;

        // Streaming with a one-cycle memory and decode always ready.
        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        // Decode never ready: exactly FQ requests may be granted.
        resetDut();
        dut_grants = 0;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("grants_full", dut_grants, FQ);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        // Two requests in flight, then a redirect that coincides with a pop
        // opportunity and an arriving response.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        // Stall then drain, to exercise the counters.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 399) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom(),
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
